// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life generation sequencer.
package life_pkg;

    localparam int N_CELLS_DEF = 64;
    localparam int GEN_W_DEF   = 16;
    localparam int RATE_W_DEF  = 16;
    localparam int CELL_IDX_W  = 6;
    localparam int CELL_CNT_W  = 7;

    localparam logic BRD_SRC_EXT = 1'b0;
    localparam logic BRD_SRC_UPD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPTURE,
        ST_TRANSFER,
        ST_WAIT
    } gen_state_t;

endpackage

// File: rtl/life_gen_sequencer_if.sv
// Command, seed-load, board-strobe and cell-stream signals between host/board and sequencer.
interface life_gen_sequencer_if #(
    parameter int GEN_W  = life_pkg::GEN_W_DEF,
    parameter int RATE_W = life_pkg::RATE_W_DEF
) ();

    logic                              cmd_load;
    logic                              cmd_step;
    logic                              cmd_run;
    logic                              cmd_pause;
    logic [RATE_W-1:0]                 rate;
    logic                              ld_valid;
    logic                              ld_bit;
    logic                              ld_ready;
    logic                              brd_shift;
    logic                              brd_src;
    logic                              brd_capture;
    logic                              brd_empty;
    logic                              brd_changed;
    logic                              cell_valid;
    logic [life_pkg::CELL_IDX_W-1:0]   cell_idx;
    logic [GEN_W-1:0]                  gen_count;
    logic                              busy;
    logic                              halted_still;
    logic                              halted_empty;

    // The master side is the host plus the board datapath; the sequencer is the slave.
    modport master (
        output cmd_load, cmd_step, cmd_run, cmd_pause, rate,
        output ld_valid, ld_bit, brd_empty, brd_changed,
        input  ld_ready, brd_shift, brd_src, brd_capture,
        input  cell_valid, cell_idx, gen_count, busy, halted_still, halted_empty
    );

    modport slave (
        input  cmd_load, cmd_step, cmd_run, cmd_pause, rate,
        input  ld_valid, ld_bit, brd_empty, brd_changed,
        output ld_ready, brd_shift, brd_src, brd_capture,
        output cell_valid, cell_idx, gen_count, busy, halted_still, halted_empty
    );

endinterface

// File: rtl/life_rate_timer.sv
// Loadable down-counter that times the idle gap between generations in run mode.
module life_rate_timer #(
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [RATE_W-1:0] load_val,
    input  logic              en,
    output logic              expire
);

    logic [RATE_W-1:0] count;

    // Expire on the cycle the count reads 1, so a load of N yields N enabled cycles.
    assign expire = en && (count == RATE_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - RATE_W'(1);
        end
    end

endmodule

// File: rtl/life_gen_sequencer.sv
// Control FSM for the 8x8 Game-of-Life board: seed load, step/run generations, cell streaming.
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int N_CELLS = N_CELLS_DEF,
    parameter int GEN_W   = GEN_W_DEF,
    parameter int RATE_W  = RATE_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    life_gen_sequencer_if.slave  bus
);

    gen_state_t              state;
    logic [CELL_CNT_W-1:0]   cell_cnt;
    logic                    run_mode;
    logic                    pause_pending;
    logic                    chg;
    logic                    empty_pending;
    logic [GEN_W-1:0]        gen_count_q;
    logic                    halted_still_q;
    logic                    halted_empty_q;

    logic                    last_cell;
    logic                    run_continue;
    logic                    timer_load;
    logic                    timer_expire;

    assign last_cell    = (cell_cnt == CELL_CNT_W'(N_CELLS - 1));
    assign run_continue = run_mode && !pause_pending && !bus.cmd_pause && chg;
    assign timer_load   = (state == ST_TRANSFER) && last_cell && run_continue && (bus.rate != '0);

    life_rate_timer #(
        .RATE_W (RATE_W)
    ) u_rate_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (bus.rate),
        .en       (state == ST_WAIT),
        .expire   (timer_expire)
    );

    // A pause never truncates a transfer; it is latched and honoured at the generation boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cell_cnt       <= '0;
            run_mode       <= 1'b0;
            pause_pending  <= 1'b0;
            chg            <= 1'b0;
            empty_pending  <= 1'b0;
            gen_count_q    <= '0;
            halted_still_q <= 1'b0;
            halted_empty_q <= 1'b0;
        end else begin
            if (empty_pending) begin
                halted_empty_q <= bus.brd_empty;
                empty_pending  <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    pause_pending <= 1'b0;
                    if (bus.cmd_pause) begin
                        run_mode <= 1'b0;
                    end else if (bus.cmd_load) begin
                        state          <= ST_LOAD;
                        cell_cnt       <= '0;
                        gen_count_q    <= '0;
                        halted_still_q <= 1'b0;
                        halted_empty_q <= 1'b0;
                        empty_pending  <= 1'b0;
                    end else if (bus.cmd_run) begin
                        run_mode <= 1'b1;
                        state    <= ST_CAPTURE;
                    end else if (bus.cmd_step) begin
                        run_mode <= 1'b0;
                        state    <= ST_CAPTURE;
                    end
                end
                ST_LOAD: begin
                    if (bus.ld_valid) begin
                        if (last_cell) begin
                            cell_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            cell_cnt <= cell_cnt + CELL_CNT_W'(1);
                        end
                    end
                end
                ST_CAPTURE: begin
                    chg      <= bus.brd_changed;
                    cell_cnt <= '0;
                    state    <= ST_TRANSFER;
                    if (bus.cmd_pause) begin
                        pause_pending <= 1'b1;
                    end
                end
                ST_TRANSFER: begin
                    if (bus.cmd_pause) begin
                        pause_pending <= 1'b1;
                    end
                    if (last_cell) begin
                        cell_cnt       <= '0;
                        halted_still_q <= ~chg;
                        empty_pending  <= 1'b1;
                        if (gen_count_q != '1) begin
                            gen_count_q <= gen_count_q + GEN_W'(1);
                        end
                        if (run_continue) begin
                            state <= (bus.rate == '0) ? ST_CAPTURE : ST_WAIT;
                        end else begin
                            state         <= ST_IDLE;
                            run_mode      <= 1'b0;
                            pause_pending <= 1'b0;
                        end
                    end else begin
                        cell_cnt <= cell_cnt + CELL_CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (bus.cmd_pause) begin
                        state    <= ST_IDLE;
                        run_mode <= 1'b0;
                    end else if (timer_expire) begin
                        state <= ST_CAPTURE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ld_ready     = (state == ST_LOAD);
    assign bus.brd_shift    = ((state == ST_LOAD) && bus.ld_valid) || (state == ST_TRANSFER);
    assign bus.brd_src      = (state == ST_TRANSFER) ? BRD_SRC_UPD : BRD_SRC_EXT;
    assign bus.brd_capture  = (state == ST_CAPTURE);
    assign bus.cell_valid   = (state == ST_TRANSFER);
    assign bus.cell_idx     = (state == ST_TRANSFER) ? cell_cnt[CELL_IDX_W-1:0] : '0;
    assign bus.gen_count    = gen_count_q;
    assign bus.busy         = (state != ST_IDLE);
    assign bus.halted_still = halted_still_q;
    assign bus.halted_empty = halted_empty_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Scoreboard bench for life_gen_sequencer: directed scenarios push expected events, a monitor checks them.
module tb_life_gen_sequencer;
    import life_pkg::*;

    localparam int K_LOAD = 0;
    localparam int K_CAP  = 1;
    localparam int K_CELL = 2;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_cap    = 0;
    exp_t exp_q[$];

    life_gen_sequencer_if #(.GEN_W(16), .RATE_W(16)) bus ();

    life_gen_sequencer #(
        .N_CELLS (64),
        .GEN_W   (16),
        .RATE_W  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(string name, int actual, int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic push_exp(int kind, int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // One generation: a capture strobe (gap -1 = first of a sequence) followed by ncells cells.
    task automatic push_gen(int gap, int ncells);
        push_exp(K_CAP, gap);
        for (int i = 0; i < ncells; i++) push_exp(K_CELL, i);
    endtask

    task automatic handle_event(int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_output("unexpected_event", kind, -1);
            return;
        end
        e = exp_q.pop_front();
        check_output("event_kind", kind, e.kind);
        if (kind != e.kind) return;
        case (kind)
            K_CAP: begin
                if (e.val >= 0) check_output("capture_gap", cyc - last_cap, e.val);
                else check_output("capture_no_shift", int'({bus.brd_shift, bus.cell_valid}), 0);
                last_cap = cyc;
            end
            K_CELL: check_output("cell_shift_src_idx",
                                 int'({bus.brd_shift, bus.brd_src, bus.cell_idx}), 192 + e.val);
            default: check_output("load_src_ready_cap",
                                  int'({bus.brd_src, bus.ld_ready, bus.brd_capture}), 2);
        endcase
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.brd_capture) handle_event(K_CAP);
                if (bus.cell_valid) handle_event(K_CELL);
                else if (bus.brd_shift && !bus.brd_src) handle_event(K_LOAD);
            end
        end
    end

    task automatic apply_stimulus(bit load, bit run, bit step, bit pause);
        @(posedge clk); #1;
        bus.cmd_load  = load;
        bus.cmd_run   = run;
        bus.cmd_step  = step;
        bus.cmd_pause = pause;
        @(posedge clk); #1;
        bus.cmd_load  = 1'b0;
        bus.cmd_run   = 1'b0;
        bus.cmd_step  = 1'b0;
        bus.cmd_pause = 1'b0;
    endtask

    task automatic pause_now();
        bus.cmd_pause = 1'b1;
        @(posedge clk); #1;
        bus.cmd_pause = 1'b0;
    endtask

    task automatic wait_idx(int idx, int times);
        int seen = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (bus.cell_valid && int'(bus.cell_idx) == idx) begin
                seen++;
                if (seen == times) return;
            end
        end
        check_output("wait_idx_timeout", seen, times);
    endtask

    task automatic wait_idle(int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (!bus.busy) return;
        end
        check_output("wait_idle_timeout", int'(bus.busy), 0);
    endtask

    task automatic load_board(bit toggling, bit with_run);
        int n;
        n = toggling ? 128 : 64;
        for (int i = 0; i < 64; i++) push_exp(K_LOAD, i);
        apply_stimulus(1'b1, with_run, 1'b0, 1'b0);
        if (with_run) check_output("prio_load_over_run", int'({bus.ld_ready, bus.brd_capture}), 2);
        for (int i = 0; i < n; i++) begin
            bus.ld_valid = toggling ? (i % 2 == 0) : 1'b1;
            bus.ld_bit   = i[0];
            if (i == n - (toggling ? 2 : 1)) check_output("load_busy_before_last", int'(bus.busy), 1);
            @(posedge clk); #1;
        end
        bus.ld_valid = 1'b0;
        check_output("load_idle_after", int'(bus.busy), 0);
        check_output("load_gen_cleared", int'(bus.gen_count), 0);
    endtask

    initial begin : stimulus
        bus.cmd_load = 1'b0; bus.cmd_step = 1'b0; bus.cmd_run = 1'b0; bus.cmd_pause = 1'b0;
        bus.rate = '0; bus.ld_valid = 1'b0; bus.ld_bit = 1'b0;
        bus.brd_empty = 1'b0; bus.brd_changed = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", int'(bus.busy), 0);
        check_output("reset_outputs", int'({bus.cell_valid, bus.ld_ready, bus.brd_shift, bus.brd_capture}), 0);
        check_output("reset_gen", int'(bus.gen_count), 0);
        check_output("reset_flags", int'({bus.halted_still, bus.halted_empty}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Seed load with ld_valid toggling every other cycle.
        load_board(1'b1, 1'b0);

        // Single step on a blinker.
        bus.brd_changed = 1'b1;
        push_gen(-1, 64);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle(200);
        check_output("step_gen", int'(bus.gen_count), 1);
        check_output("step_still", int'(bus.halted_still), 0);
        @(posedge clk); #1;
        check_output("step_empty", int'(bus.halted_empty), 0);

        // Free-run rate=10; cmd_step in WAIT ignored; pause mid-transfer of third generation.
        bus.rate = 16'd10;
        push_gen(-1, 64); push_gen(75, 64); push_gen(75, 64);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        wait_idx(63, 1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        wait_idx(20, 2);
        pause_now();
        check_output("pause_no_truncate", int'(bus.busy), 1);
        wait_idle(200);
        check_output("run_gen", int'(bus.gen_count), 4);
        check_output("run_still", int'(bus.halted_still), 0);

        // Pause while in WAIT returns to IDLE on the next edge.
        bus.rate = 16'd20;
        push_gen(-1, 64);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        wait_idx(63, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pause_now();
        check_output("wait_pause_idle", int'(bus.busy), 0);
        check_output("wait_pause_gen", int'(bus.gen_count), 5);

        // rate=0: back-to-back 65-cycle generations.
        bus.rate = 16'd0;
        push_gen(-1, 64); push_gen(65, 64); push_gen(65, 64);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        wait_idx(10, 3);
        pause_now();
        wait_idle(200);
        check_output("rate0_gen", int'(bus.gen_count), 8);

        // cmd_load + cmd_run together: load wins and clears the generation count.
        load_board(1'b0, 1'b1);
        check_output("reload_flags", int'({bus.halted_still, bus.halted_empty}), 0);

        // Still life in run mode halts after one generation.
        bus.brd_changed = 1'b0;
        bus.rate = 16'd5;
        push_gen(-1, 64);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle(200);
        check_output("still_gen", int'(bus.gen_count), 1);
        check_output("still_flag", int'(bus.halted_still), 1);
        @(posedge clk); #1;
        check_output("still_not_empty", int'(bus.halted_empty), 0);

        // Extinct board.
        bus.brd_empty = 1'b1;
        push_gen(-1, 64);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle(200);
        check_output("empty_gen", int'(bus.gen_count), 2);
        @(posedge clk); #1;
        check_output("empty_flags", int'({bus.halted_still, bus.halted_empty}), 3);

        // Asynchronous reset mid-transfer at cell_idx=30.
        bus.brd_empty   = 1'b0;
        bus.brd_changed = 1'b1;
        push_gen(-1, 31);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        wait_idx(30, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("async_rst_busy", int'(bus.busy), 0);
        @(posedge clk); #1;
        check_output("rst_mid_busy_valid", int'({bus.busy, bus.cell_valid}), 0);
        check_output("rst_mid_gen", int'(bus.gen_count), 0);
        check_output("rst_mid_flags", int'({bus.halted_still, bus.halted_empty}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
